// File: rtl/svc_sched_pkg.sv
// svc_sched_pkg: shared types and service codes for the service scheduler.
// FSM state encoding, request bundle and vector codes driven onto CS ADDR.
package svc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DISPATCH,
        WAIT_ACK
    } state_t;

    localparam logic [2:0] CODE_ACLO  = 3'b111;
    localparam logic [2:0] CODE_HALT  = 3'b110;
    localparam logic [2:0] CODE_TRACE = 3'b101;
    localparam logic [2:0] CODE_TIMER = 3'b011;
    localparam logic [2:0] CODE_INT   = 3'b010;
    localparam logic [2:0] CODE_NONE  = 3'b000;

    // Active-high service requests, highest priority first.
    typedef struct packed {
        logic aclo;
        logic halt;
        logic trace;
        logic timer;
        logic intr;
    } req_t;

endpackage

// File: rtl/svc_prio_enc.sv
// svc_prio_enc: fixed-priority encoder from service requests to vector code.
// ACLO > HALT > TRACE > TIMER > INT; no request gives CODE_NONE.
module svc_prio_enc
    import svc_sched_pkg::*;
(
    input  req_t       req,
    output logic [2:0] code,
    output logic       valid
);

    // Pick the highest-priority active request.
    always_comb begin
        code  = CODE_NONE;
        valid = 1'b1;
        priority case (1'b1)
            req.aclo:  code = CODE_ACLO;
            req.halt:  code = CODE_HALT;
            req.trace: code = CODE_TRACE;
            req.timer: code = CODE_TIMER;
            req.intr:  code = CODE_INT;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/svc_sched.sv
// svc_sched: service request scheduler for the DPM microsequencer.
// Optional ack watchdog enabled by defining SVC_SCHED_WATCHDOG_EN.
module svc_sched
    import svc_sched_pkg::*;
#(
    parameter int HOLDOFF_CYC = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       buf_m_clk_l,
    input  logic       sac_reset_h,
    input  logic       d_clk_enable_h,
    input  logic       sync_aclo_h,
    input  logic       con_halt_l,
    input  logic       psl_tp_h,
    input  logic       tmr_svc_h,
    input  logic       int_pend_l,
    input  logic       ld_ir_l,
    input  logic       but_svc_h,
    input  logic       svc_ack_h,
    output logic       do_service_l,
    output logic [2:0] cs_addr_l,
    output logic       svc_busy_h,
    output logic       svc_err_h
);

    state_t     state;
    logic       aclo_prev;
    logic       aclo_lat;
    logic [3:0] holdoff;
    logic [2:0] code_q;
    logic [2:0] win_code;
    logic       win_valid;
    logic [2:0] pend_code;
    logic       ack_take;
    req_t       req;

    assign req.aclo  = aclo_lat;
    assign req.halt  = ~con_halt_l;
    assign req.trace = psl_tp_h;
    assign req.timer = tmr_svc_h;
    assign req.intr  = ~int_pend_l;

    // A late ACLO still pre-empts a service that has not dispatched yet.
    assign pend_code = aclo_lat ? CODE_ACLO : code_q;
    assign ack_take  = (state == WAIT_ACK) && svc_ack_h;

    svc_prio_enc u_enc (
        .req   (req),
        .code  (win_code),
        .valid (win_valid)
    );

    // ACLO rising-edge capture; held until its own service is acknowledged.
    always_ff @(posedge buf_m_clk_l or posedge sac_reset_h) begin
        if (sac_reset_h) begin
            aclo_prev <= 1'b0;
            aclo_lat  <= 1'b0;
        end else if (d_clk_enable_h) begin
            aclo_prev <= sync_aclo_h;
            if (sync_aclo_h && !aclo_prev)
                aclo_lat <= 1'b1;
            else if (ack_take && code_q == CODE_ACLO)
                aclo_lat <= 1'b0;
        end
    end

`ifdef SVC_SCHED_WATCHDOG_EN
    logic [7:0] wd_cnt;
`else
    assign svc_err_h = 1'b0;
`endif

    // Scheduler FSM with registered handshake outputs and holdoff counter.
    always_ff @(posedge buf_m_clk_l or posedge sac_reset_h) begin
        if (sac_reset_h) begin
            state        <= IDLE;
            holdoff      <= 4'd0;
            code_q       <= CODE_NONE;
            cs_addr_l    <= 3'b111;
            do_service_l <= 1'b1;
            svc_busy_h   <= 1'b0;
`ifdef SVC_SCHED_WATCHDOG_EN
            wd_cnt       <= 8'd0;
            svc_err_h    <= 1'b0;
`endif
        end else if (d_clk_enable_h) begin
            unique case (state)
                IDLE: begin
                    if (holdoff != 4'd0) begin
                        holdoff <= holdoff - 4'd1;
                    end else if (win_valid && !ld_ir_l) begin
                        state        <= PEND;
                        code_q       <= win_code;
                        do_service_l <= 1'b0;
                        svc_busy_h   <= 1'b1;
                    end
                end
                PEND: begin
                    code_q <= pend_code;
                    if (but_svc_h) begin
                        state     <= DISPATCH;
                        cs_addr_l <= ~pend_code;
                    end
                end
                DISPATCH: begin
                    state        <= WAIT_ACK;
                    cs_addr_l    <= 3'b111;
                    do_service_l <= 1'b1;
`ifdef SVC_SCHED_WATCHDOG_EN
                    wd_cnt       <= 8'd0;
`endif
                end
                WAIT_ACK: begin
                    if (svc_ack_h) begin
                        state      <= IDLE;
                        holdoff    <= 4'(HOLDOFF_CYC);
                        svc_busy_h <= 1'b0;
                    end
`ifdef SVC_SCHED_WATCHDOG_EN
                    else if (wd_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        state      <= IDLE;
                        holdoff    <= 4'(HOLDOFF_CYC);
                        svc_busy_h <= 1'b0;
                        svc_err_h  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svc_sched.sv
// tb_svc_sched: directed scoreboard bench for svc_sched.
// Expected dispatch codes are queued by the driver and checked by a monitor.
`timescale 1ns/1ps
module tb_svc_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       aclo;
    logic       halt_l;
    logic       tp;
    logic       tmr;
    logic       int_l;
    logic       ld_ir_l;
    logic       but;
    logic       ack;
    logic       do_l;
    logic [2:0] cs;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    svc_sched #(.HOLDOFF_CYC(4), .ACK_TIMEOUT(8)) dut (
        .buf_m_clk_l    (clk),
        .sac_reset_h    (rst),
        .d_clk_enable_h (en),
        .sync_aclo_h    (aclo),
        .con_halt_l     (halt_l),
        .psl_tp_h       (tp),
        .tmr_svc_h      (tmr),
        .int_pend_l     (int_l),
        .ld_ir_l        (ld_ir_l),
        .but_svc_h      (but),
        .svc_ack_h      (ack),
        .do_service_l   (do_l),
        .cs_addr_l      (cs),
        .svc_busy_h     (busy),
        .svc_err_h      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: every cycle with cs_addr_l driven must match the next queued code.
    always @(negedge clk) begin
        if (!rst && cs !== 3'b111) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL dispatch_unexpected: got cs %b expected none", cs);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (cs !== e || do_l !== 1'b0) begin
                    n_err++;
                    $display("FAIL dispatch: got cs %b do %b expected cs %b do 0",
                             cs, do_l, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; aclo = 1'b0; halt_l = 1'b1; tp = 1'b0;
        tmr = 1'b0; int_l = 1'b1; ld_ir_l = 1'b1; but = 1'b0; ack = 1'b0;
        step(3);
        chk("rst_cs", cs, 3'b111);
        chk("rst_do", {2'b0, do_l}, 3'd1);
        chk("rst_busy", {2'b0, busy}, 3'd0);
        chk("rst_err", {2'b0, err}, 3'd0);
        rst = 1'b0;
        step(1);

        // INT at boundary, dispatch shows ~010
        int_l = 1'b0; ld_ir_l = 1'b0;
        step(1);
        ld_ir_l = 1'b1;
        chk("int_pend_do", {2'b0, do_l}, 3'd0);
        chk("int_pend_busy", {2'b0, busy}, 3'd1);
        exp_q.push_back(3'b101);
        but = 1'b1; step(1); but = 1'b0;
        step(1);
        chk("int_wait_do", {2'b0, do_l}, 3'd1);
        chk("int_wait_cs", cs, 3'b111);
        int_l = 1'b1; ack = 1'b1; step(1); ack = 1'b0;
        chk("int_ack_idle", {2'b0, busy}, 3'd0);

        // HALT beats TIMER; holdoff blocks the first four boundaries
        halt_l = 1'b0; tmr = 1'b1; ld_ir_l = 1'b0;
        step(4);
        chk("holdoff_block", {2'b0, busy}, 3'd0);
        step(1);
        ld_ir_l = 1'b1;
        chk("halt_pend", {2'b0, busy}, 3'd1);
        exp_q.push_back(3'b001);
        but = 1'b1; step(1); but = 1'b0;
        step(1);
        halt_l = 1'b1; ack = 1'b1; step(1); ack = 1'b0;

        // TIMER dispatched next
        ld_ir_l = 1'b0;
        step(4);
        chk("holdoff_block2", {2'b0, busy}, 3'd0);
        step(1);
        ld_ir_l = 1'b1;
        exp_q.push_back(3'b100);
        but = 1'b1; step(1); but = 1'b0;
        step(1);
        ack = 1'b1; step(1); ack = 1'b0;

        // TIMER pending, ACLO edge upgrades it before dispatch
        ld_ir_l = 1'b0;
        step(5);
        ld_ir_l = 1'b1;
        chk("timer_pend", {2'b0, busy}, 3'd1);
        aclo = 1'b1; step(1);
        aclo = 1'b0; step(1);
        exp_q.push_back(3'b000);
        but = 1'b1; step(1); but = 1'b0;
        tmr = 1'b0; int_l = 1'b0;
        step(1);

        // clock enable low in WAIT_ACK freezes everything, ack included
        en = 1'b0; ack = 1'b1;
        step(10);
        chk("frz_busy", {2'b0, busy}, 3'd1);
        chk("frz_do", {2'b0, do_l}, 3'd1);
        en = 1'b1; step(1); ack = 1'b0;
        chk("aclo_ack_idle", {2'b0, busy}, 3'd0);

        // holdoff frozen while disabled; ACLO cleared so INT wins next
        ld_ir_l = 1'b0; en = 1'b0;
        step(10);
        chk("frz_idle", {2'b0, busy}, 3'd0);
        en = 1'b1;
        step(4);
        chk("frz_holdoff", {2'b0, busy}, 3'd0);
        step(1);
        ld_ir_l = 1'b1;
        chk("int2_pend", {2'b0, busy}, 3'd1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ack_ignored_busy", {2'b0, busy}, 3'd1);
        chk("ack_ignored_do", {2'b0, do_l}, 3'd0);
        exp_q.push_back(3'b101);
        but = 1'b1; step(1); but = 1'b0;
        step(1);
        int_l = 1'b1; ack = 1'b1; step(1); ack = 1'b0;

        // reset in the middle of a HALT dispatch
        halt_l = 1'b0; ld_ir_l = 1'b0;
        step(5);
        ld_ir_l = 1'b1;
        but = 1'b1; step(1); but = 1'b0;
        chk("mid_disp_cs", cs, 3'b001);
        rst = 1'b1; #1;
        chk("rst_disp_cs", cs, 3'b111);
        chk("rst_disp_busy", {2'b0, busy}, 3'd0);
        chk("rst_disp_do", {2'b0, do_l}, 3'd1);
        step(2);
        rst = 1'b0; halt_l = 1'b1;
        step(1);

        // no ack: watchdog timeout or indefinite wait
        int_l = 1'b0; ld_ir_l = 1'b0;
        step(1);
        ld_ir_l = 1'b1;
        exp_q.push_back(3'b101);
        but = 1'b1; step(1); but = 1'b0;
        step(1);
        int_l = 1'b1;
`ifdef SVC_SCHED_WATCHDOG_EN
        step(7);
        chk("wd_before", {2'b0, busy}, 3'd1);
        chk("wd_err_before", {2'b0, err}, 3'd0);
        step(1);
        chk("wd_idle", {2'b0, busy}, 3'd0);
        chk("wd_err", {2'b0, err}, 3'd1);
        step(5);
        chk("wd_err_sticky", {2'b0, err}, 3'd1);
`else
        step(20);
        chk("noack_busy", {2'b0, busy}, 3'd1);
        chk("noack_err", {2'b0, err}, 3'd0);
`endif
        rst = 1'b1; #1;
        chk("final_rst_err", {2'b0, err}, 3'd0);
        step(2);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/svc_sched.md
Name: svc_sched

Overview:
- Service request scheduler for the DPM microsequencer.
- Collects asynchronous-origin service conditions (power fail, console halt, trace pending, interval timer, UBI interrupt) and prioritises them.
- At an instruction boundary it asserts DO SRVC L and, on the microcode's service BUT, drives a vector code onto the low CS ADDR bits through the existing wired-AND.
- A holdoff counter guarantees at least one instruction completes between successive services.

Parameters:
- HOLDOFF_CYC, 4: enabled clocks after ack before a new service may be scheduled (1..15).
- ACK_TIMEOUT, 255: WAIT_ACK cycle limit; used only with the optional feature (1..255).

Ports:
- buf_m_clk_l  in  1  microcycle clock; all state updates on rising edge, qualified by d_clk_enable_h
- sac_reset_h  in  1  reset, asynchronous, active-high
- d_clk_enable_h  in  1  clock enable; no state change when low
- sync_aclo_h  in  1  synchronised AC low; edge-captured
- con_halt_l  in  1  console halt request, level
- psl_tp_h  in  1  trace pending, level
- tmr_svc_h  in  1  interval timer service, level
- int_pend_l  in  1  UBI interrupt pending, level
- ld_ir_l  in  1  instruction boundary strobe (IR load)
- but_svc_h  in  1  current BUT is the service dispatch branch
- svc_ack_h  in  1  microcode has entered the service routine
- do_service_l  out  1  service pending at boundary, low-true
- cs_addr_l  out  3  wired-AND contribution to CS ADDR[2:0]; 3'b111 when not driving
- svc_busy_h  out  1  FSM not in IDLE
- svc_err_h  out  1  sticky ack-timeout flag (optional feature only; else constant 0)

Behaviour:
- Reset (async): FSM=IDLE, aclo_lat=0, holdoff=0, cs_addr_l=3'b111, do_service_l=1, svc_busy_h=0, svc_err_h=0.
- aclo_lat sets on rising edge of sync_aclo_h (registered previous value); clears only on svc_ack_h while code=ACLO.
- Priority and code, highest first: ACLO=3'b111, HALT=3'b110, TRACE=3'b101, TIMER=3'b011, INT=3'b010. No request: code=3'b000.
- States:
  - IDLE: if holdoff==0, request present and ld_ir_l==0 -> PEND; latch winning code into code_q.
  - PEND: do_service_l=0. When but_svc_h=1 -> DISPATCH.
  - DISPATCH: one cycle; cs_addr_l=~code_q; do_service_l=0 -> WAIT_ACK.
  - WAIT_ACK: do_service_l=1. On svc_ack_h -> IDLE; holdoff loaded with HOLDOFF_CYC.
- code_q is frozen from PEND entry. A higher-priority arrival during PEND/DISPATCH/WAIT_ACK is serviced on the next boundary.
- Exception: ACLO arriving in PEND (before DISPATCH) upgrades code_q to ACLO.
- Holdoff decrements once per enabled clock in IDLE, saturating at 0.
- ld_ir_l low in the same cycle as holdoff reaching 0 is not a boundary; the next ld_ir_l is.
- svc_ack_h outside WAIT_ACK: ignored.
- If a request deasserts in PEND, remain in PEND; the routine handles the null case. ACLO is sticky regardless.
- d_clk_enable_h low freezes all state, including the edge detector.
- Reset mid-service returns to IDLE immediately and releases cs_addr_l.

Optional Feature:
- SVC_SCHED_WATCHDOG_EN defined: an 8-bit counter runs in WAIT_ACK.
  - Reaching ACK_TIMEOUT without an ack forces IDLE, sets svc_err_h (cleared by reset only) and loads holdoff.
- Undefined: no counter; WAIT_ACK waits indefinitely; svc_err_h tied 0.

Decomposition:
- Package svc_sched_pkg: FSM state enum (IDLE, PEND, DISPATCH, WAIT_ACK) and the five 3-bit service code constants.
- Sub-module svc_prio_enc: combinational priority encoder from request vector to code plus valid.

Test Plan:
- Reset mid-DISPATCH with code 3'b110 -> cs_addr_l=3'b111, svc_busy_h=0 in the same cycle; do_service_l=1.
- int_pend_l=0, ld_ir_l pulse, but_svc_h next cycle -> do_service_l low one cycle after boundary; cs_addr_l=3'b101 for exactly 1 cycle.
- tmr_svc_h=1 and con_halt_l=0 together at boundary -> code 3'b110 dispatched. After ack plus 4 cycles of holdoff, next boundary dispatches 3'b011.
- ACLO rising edge while in PEND with TIMER -> dispatch shows cs_addr_l=3'b000. aclo_lat survives deassertion of sync_aclo_h until ack.
- d_clk_enable_h held low 10 cycles during WAIT_ACK -> no state or holdoff change.
- With SVC_SCHED_WATCHDOG_EN and ACK_TIMEOUT=8, no ack -> IDLE after 8 cycles, svc_err_h=1 until reset.
